// File: rtl/pll_lock_sequencer_if.sv
// Signal bundle between the PLL lock sequencer and its surroundings.
// The master side is the sequencer: it watches the PLL lock and the
// reconfiguration request, and drives the PLL reset, core reset and status.
interface pll_lock_sequencer_if;
  logic       pll_locked;    // PLL locked output, asynchronous to refclk
  logic       reconfig_req;  // single-cycle request to re-lock the PLL
  logic       pll_rst;       // reset to the PLL, active-high
  logic       sys_rst;       // core reset, active-high
  logic       ready;         // high only while running
  logic       fault;         // high only in the fault state
  logic [2:0] retry_cnt;     // timeouts in the current sequence, saturating
  logic [7:0] lost_cnt;      // lock-loss events while running, saturating

  modport master (
    input  pll_locked,
    input  reconfig_req,
    output pll_rst,
    output sys_rst,
    output ready,
    output fault,
    output retry_cnt,
    output lost_cnt
  );

  modport slave (
    output pll_locked,
    output reconfig_req,
    input  pll_rst,
    input  sys_rst,
    input  ready,
    input  fault,
    input  retry_cnt,
    input  lost_cnt
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL power-up / recovery sequencer.
// Holds the PLL in reset for a fixed number of refclk cycles, then waits for
// the synchronized lock to stay high for STABLE_CYCLES consecutive cycles
// before releasing the core reset. A lock that does not settle within
// LOCK_TIMEOUT cycles triggers a retry; MAX_RETRY timeouts park the sequencer
// in FAULT, where it still releases the core if the lock later settles.
// Everything runs on refclk so the sequencer keeps working with no PLL output.
module pll_lock_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int STABLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int MAX_RETRY     = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                 refclk,
  input  logic                 rst,
  pll_lock_sequencer_if.master seq_if
);

  // Reset counter only needs to reach RST_CYCLES-1; the other two must be
  // able to hold their terminal value.
  localparam int RST_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int STABLE_W = $clog2(STABLE_CYCLES + 1);
  localparam int TO_W     = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_RESET_PLL = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RUN       = 2'd2,
    ST_FAULT     = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // Lock synchronizer
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lk;

  // Shift the asynchronous lock flag through the synchronizer chain.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], seq_if.pll_locked};
    end
  end

  assign lk = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------
  // Sequencer state
  // ---------------------------------------------------------------------
  state_t              state_q,  state_d;
  logic [RST_W-1:0]    rst_cnt_q, rst_cnt_d;
  logic [TO_W-1:0]     to_cnt_q,  to_cnt_d;
  logic [STABLE_W-1:0] stable_q,  stable_d;
  logic [2:0]          retry_q,   retry_d;
  logic [7:0]          lost_q,    lost_d;

  logic                pll_rst_q;
  logic                sys_rst_q;
  logic                ready_q;
  logic                fault_q;

  // Helper values shared by several states.
  logic [STABLE_W-1:0] stable_inc;
  logic [STABLE_W-1:0] stable_nxt;
  logic [TO_W-1:0]     to_inc;
  logic [2:0]          retry_inc;
  logic [7:0]          lost_inc;
  logic                stable_done;
  logic                timeout_hit;

  // Next-state logic; reconfig_req is applied last so it overrides every
  // other transition taken in the same cycle.
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    to_cnt_d  = to_cnt_q;
    stable_d  = stable_q;
    retry_d   = retry_q;
    lost_d    = lost_q;

    stable_inc  = stable_q + STABLE_W'(1);
    stable_nxt  = lk ? stable_inc : '0;
    to_inc      = to_cnt_q + TO_W'(1);
    retry_inc   = (retry_q == 3'd7) ? retry_q : retry_q + 3'd1;
    lost_inc    = (lost_q == 8'hFF) ? lost_q : lost_q + 8'd1;
    stable_done = lk && (stable_inc == STABLE_W'(STABLE_CYCLES));
    timeout_hit = (to_inc == TO_W'(LOCK_TIMEOUT));

    case (state_q)
      ST_RESET_PLL: begin
        if (rst_cnt_q == RST_W'(RST_CYCLES - 1)) begin
          state_d   = ST_WAIT_LOCK;
          rst_cnt_d = '0;
          to_cnt_d  = '0;
          stable_d  = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + RST_W'(1);
        end
      end

      ST_WAIT_LOCK: begin
        to_cnt_d = to_inc;
        stable_d = stable_nxt;
        if (stable_done) begin
          // Stable completion wins over a coincident timeout.
          state_d  = ST_RUN;
          retry_d  = '0;
          to_cnt_d = '0;
          stable_d = '0;
        end else if (timeout_hit) begin
          retry_d  = retry_inc;
          to_cnt_d = '0;
          stable_d = '0;
          if (retry_inc == 3'(MAX_RETRY)) begin
            // The stable count starts afresh in FAULT rather than carrying a
            // partial run over from the window that just timed out.
            state_d = ST_FAULT;
          end else begin
            state_d   = ST_RESET_PLL;
            rst_cnt_d = '0;
          end
        end
      end

      ST_RUN: begin
        if (!lk) begin
          state_d   = ST_RESET_PLL;
          lost_d    = lost_inc;
          rst_cnt_d = '0;
          to_cnt_d  = '0;
          stable_d  = '0;
        end
      end

      ST_FAULT: begin
        // No timeout here: just wait for a stable lock.
        to_cnt_d = '0;
        stable_d = stable_nxt;
        if (stable_done) begin
          state_d  = ST_RUN;
          retry_d  = '0;
          stable_d = '0;
        end
      end

      default: begin
        state_d   = ST_RESET_PLL;
        rst_cnt_d = '0;
        to_cnt_d  = '0;
        stable_d  = '0;
      end
    endcase

    if (seq_if.reconfig_req) begin
      // A request in RUN is intentional, so it is not counted as a loss.
      state_d   = ST_RESET_PLL;
      rst_cnt_d = '0;
      to_cnt_d  = '0;
      stable_d  = '0;
      lost_d    = lost_q;
      if (state_q == ST_FAULT) begin
        retry_d = '0;
      end
    end
  end

  // State, counters and outputs; outputs are decoded from the next state so
  // they change on the same edge as the state itself.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RESET_PLL;
      rst_cnt_q <= '0;
      to_cnt_q  <= '0;
      stable_q  <= '0;
      retry_q   <= '0;
      lost_q    <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      to_cnt_q  <= to_cnt_d;
      stable_q  <= stable_d;
      retry_q   <= retry_d;
      lost_q    <= lost_d;
      pll_rst_q <= (state_d == ST_RESET_PLL);
      sys_rst_q <= (state_d != ST_RUN);
      ready_q   <= (state_d == ST_RUN);
      fault_q   <= (state_d == ST_FAULT);
    end
  end

  assign seq_if.pll_rst   = pll_rst_q;
  assign seq_if.sys_rst   = sys_rst_q;
  assign seq_if.ready     = ready_q;
  assign seq_if.fault     = fault_q;
  assign seq_if.retry_cnt = retry_q;
  assign seq_if.lost_cnt  = lost_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer. A stimulus process drives the lock and the
// reconfiguration request one refclk cycle at a time and, in the same step,
// advances a phase/age reference model that pushes every predicted change of
// the output vector into a queue. A monitor watching the DUT pops and compares
// each time the outputs change. Directed timing checks against fixed values
// sit alongside the scoreboard.
module tb_pll_lock_sequencer;

  localparam int RST_C     = 4;
  localparam int STABLE_C  = 8;
  localparam int TIMEOUT_C = 64;
  localparam int MAXR      = 2;

  // Output vector: {pll_rst, sys_rst, ready, fault, retry_cnt[2:0], lost_cnt[7:0]}
  localparam logic [14:0] RESET_VAL = {1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0};

  typedef struct {
    int          cyc;
    logic [14:0] val;
  } evt_t;

  logic refclk;
  logic rst;

  pll_lock_sequencer_if bus();

  pll_lock_sequencer #(
    .RST_CYCLES   (RST_C),
    .STABLE_CYCLES(STABLE_C),
    .LOCK_TIMEOUT (TIMEOUT_C),
    .MAX_RETRY    (MAXR),
    .SYNC_STAGES  (2)
  ) dut (
    .refclk(refclk),
    .rst   (rst),
    .seq_if(bus.master)
  );

  int          checks = 0;
  int          passes = 0;
  int          cyc    = 0;
  bit          mon_en = 0;
  evt_t        exp_q[$];
  logic [14:0] last_exp = RESET_VAL;

  // Reference model: phase 0=pll reset, 1=waiting for lock, 2=run, 3=fault;
  // age = cycles already spent in the phase; hist = lock input per cycle.
  bit hist[$];
  int m_ph    = 0;
  int m_age   = 0;
  int m_retry = 0;
  int m_lost  = 0;

  initial begin
    refclk = 1'b0;
    forever #5 refclk = ~refclk;
  end

  initial begin
    forever begin
      @(posedge refclk);
      cyc++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time bound expired, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [14:0] pack(int ph, int retry, int lost);
    return {ph == 0, ph != 2, ph == 2, ph == 3, 3'(retry), 8'(lost)};
  endfunction

  function automatic logic [14:0] dut_val();
    return {bus.pll_rst, bus.sys_rst, bus.ready, bus.fault, bus.retry_cnt, bus.lost_cnt};
  endfunction

  // Synchronized lock seen in the current cycle minus k: two cycles behind
  // the pin.
  function automatic bit lk_at(int k);
    int idx = hist.size() - 3 - k;
    if (idx < 0) return 1'b0;
    return hist[idx];
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d required %0d (cyc %0d)", name, act, exp, cyc);
  endtask

  task automatic push_evt(int at, logic [14:0] v);
    evt_t e;
    if (v == last_exp) return;
    if (exp_q.size() > 0 && exp_q[$].cyc == at) begin
      e = exp_q.pop_back();
    end
    e.cyc = at;
    e.val = v;
    exp_q.push_back(e);
    last_exp = v;
  endtask

  // Advance the model over the current cycle and predict the next outputs.
  task automatic model_step(bit rst_now, bit locked, bit rc);
    int nph;
    int stab;
    bit lkv;
    if (rst_now) begin
      hist.push_back(1'b0);
      m_ph = 0; m_age = 0; m_retry = 0; m_lost = 0;
      push_evt(cyc, pack(0, 0, 0));
      return;
    end
    hist.push_back(locked);
    lkv  = lk_at(0);
    stab = 0;
    while (stab <= m_age && lk_at(stab)) stab++;
    nph = m_ph;
    if (rc) begin
      if (m_ph == 3) m_retry = 0;
      nph = 0;
    end else begin
      case (m_ph)
        0: if (m_age + 1 == RST_C) nph = 1;
        1: begin
          if (stab == STABLE_C) begin
            nph = 2; m_retry = 0;
          end else if (m_age + 1 == TIMEOUT_C) begin
            m_retry = (m_retry < 7) ? m_retry + 1 : 7;
            nph = (m_retry == MAXR) ? 3 : 0;
          end
        end
        2: if (!lkv) begin
          nph = 0;
          m_lost = (m_lost < 255) ? m_lost + 1 : 255;
        end
        default: if (stab == STABLE_C) begin
          nph = 2; m_retry = 0;
        end
      endcase
    end
    m_age = (rc || nph != m_ph) ? 0 : m_age + 1;
    m_ph  = nph;
    push_evt(cyc + 1, pack(m_ph, m_retry, m_lost));
  endtask

  task automatic step(bit locked, bit rc);
    bus.pll_locked   = locked;
    bus.reconfig_req = rc;
    model_step(rst, locked, rc);
    @(posedge refclk);
    #1;
    bus.reconfig_req = 1'b0;
  endtask

  // Monitor: one comparison per observed change of the DUT output vector.
  initial begin
    logic [14:0] cur;
    logic [14:0] last_dut;
    evt_t        e;
    last_dut = RESET_VAL;
    forever begin
      @(negedge refclk);
      if (mon_en) begin
        cur = dut_val();
        if (cur !== last_dut) begin
          checks++;
          if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event cyc=%0d got=%h required=no change from %h",
                     cyc, cur, last_dut);
          end else begin
            e = exp_q.pop_front();
            if (cur === e.val && cyc == e.cyc) begin
              passes++;
              $display("evt cyc=%0d outputs=%h matches model", cyc, cur);
            end else begin
              $display("FAIL event cyc=%0d got=%h required=%h at cyc=%0d",
                       cyc, cur, e.val, e.cyc);
            end
          end
          last_dut = cur;
        end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          e = exp_q.pop_front();
          checks++;
          $display("FAIL missing_event cyc=%0d got=%h required=%h at cyc=%0d",
                   cyc, cur, e.val, e.cyc);
        end
      end
    end
  end

  initial begin
    int n, hi, t0, pulses, win_start, wins, win1, win2, retry_seen;
    bit prev;

    rst = 1'b1;
    bus.pll_locked   = 1'b0;
    bus.reconfig_req = 1'b0;
    repeat (3) @(posedge refclk);
    #1;

    // Reset state
    chk("reset_pll_rst",   bus.pll_rst,   1);
    chk("reset_sys_rst",   bus.sys_rst,   1);
    chk("reset_ready",     bus.ready,     0);
    chk("reset_fault",     bus.fault,     0);
    chk("reset_retry_cnt", bus.retry_cnt, 0);
    chk("reset_lost_cnt",  bus.lost_cnt,  0);
    mon_en = 1'b1;
    step(0, 0);
    step(0, 0);
    rst = 1'b0;

    // Clean lock: lock rises 10 cycles into the wait window
    hi = 0; n = 0;
    while (bus.pll_rst && n < 50) begin hi++; step(0, 0); n++; end
    chk("s1_pll_rst_width", hi, RST_C);
    t0 = cyc;
    repeat (10) step(0, 0);
    n = 0;
    while (!bus.ready && n < 100) begin step(1, 0); n++; end
    chk("s1_release_delay", cyc - t0, 10 + 2 + STABLE_C);
    chk("s1_sys_rst", bus.sys_rst, 0);
    repeat (5) step(1, 0);

    // Reconfig in RUN with no prior losses
    step(1, 1);
    chk("rcfg_pll_rst", bus.pll_rst, 1);
    chk("rcfg_ready",   bus.ready,   0);
    hi = 0; n = 0;
    while (bus.pll_rst && n < 50) begin hi++; step(0, 0); n++; end
    chk("rcfg_pll_rst_width", hi, RST_C);

    // Glitch during stabilization
    repeat (5) step(1, 0);
    step(0, 0);
    t0 = cyc; n = 0;
    while (!bus.ready && n < 100) begin step(1, 0); n++; end
    chk("s2_release_after_rerise", cyc - t0, 2 + STABLE_C);
    chk("s2_lost_cnt", bus.lost_cnt, 0);

    // Lock loss in RUN for one cycle
    repeat (3) step(1, 0);
    step(0, 0);
    n = 0;
    while (bus.ready && n < 20) begin step(1, 0); n++; end
    chk("s5_lost_cnt", bus.lost_cnt, 1);
    chk("s5_sys_rst",  bus.sys_rst,  1);
    hi = 0; n = 0;
    while (bus.pll_rst && n < 50) begin hi++; step(1, 0); n++; end
    chk("s5_pll_rst_width", hi, RST_C);
    n = 0;
    while (!bus.ready && n < 200) begin step(1, 0); n++; end
    chk("s5_relock", bus.ready, 1);

    // Reconfig in RUN leaves lost_cnt alone
    repeat (3) step(1, 0);
    step(1, 1);
    chk("s5_rcfg_pll_rst",  bus.pll_rst,  1);
    chk("s5_rcfg_lost_cnt", bus.lost_cnt, 1);

    // Timeout and fault with the lock held low
    pulses = 1; prev = 1'b1; win_start = -1; wins = 0;
    win1 = 0; win2 = 0; retry_seen = 0; n = 0;
    while (!bus.fault && n < 400) begin
      step(0, 0); n++;
      if (bus.pll_rst && !prev) pulses++;
      if (!bus.pll_rst && prev) win_start = cyc;
      if (win_start >= 0 && (bus.pll_rst || bus.fault)) begin
        wins++;
        if (wins == 1) begin win1 = cyc - win_start; retry_seen = bus.retry_cnt; end
        else win2 = cyc - win_start;
        win_start = -1;
      end
      prev = bus.pll_rst;
    end
    chk("s3_fault",        bus.fault,     1);
    chk("s3_retry_cnt",    bus.retry_cnt, MAXR);
    chk("s3_first_retry",  retry_seen,    1);
    chk("s3_pll_rst_pulses", pulses,      2);
    chk("s3_window1",      win1,          TIMEOUT_C);
    chk("s3_window2",      win2,          TIMEOUT_C);

    // Recovery from FAULT
    repeat (3) step(0, 0);
    chk("s4_still_fault", bus.fault, 1);
    t0 = cyc; n = 0;
    while (!bus.ready && n < 100) begin step(1, 0); n++; end
    chk("s4_delay",     cyc - t0,      2 + STABLE_C);
    chk("s4_fault",     bus.fault,     0);
    chk("s4_retry_cnt", bus.retry_cnt, 0);

    // Async reset in the middle of the wait window
    repeat (2) step(1, 0);
    step(0, 1);
    n = 0;
    while (bus.pll_rst && n < 50) begin step(0, 0); n++; end
    repeat (20) step(0, 0);
    rst = 1'b1;
    #1;
    chk("s6_async_pll_rst", bus.pll_rst,   1);
    chk("s6_async_sys_rst", bus.sys_rst,   1);
    chk("s6_async_lost",    bus.lost_cnt,  0);
    chk("s6_async_retry",   bus.retry_cnt, 0);
    step(0, 0);
    step(0, 0);
    rst = 1'b0;

    // Reconfig on the very cycle the stable count completes
    n = 0;
    while (bus.pll_rst && n < 50) begin step(0, 0); n++; end
    repeat (9) step(1, 0);
    step(1, 1);
    chk("s6_simul_pll_rst", bus.pll_rst, 1);
    chk("s6_simul_ready",   bus.ready,   0);
    step(1, 0);
    chk("s6_simul_ready_next", bus.ready, 0);

    // Randomized lock waveform with occasional reconfig requests
    for (int seg = 0; seg < 120; seg++) begin
      bit lv;
      int len;
      lv  = ($urandom_range(0, 9) < 6);
      len = lv ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 90));
      for (int k = 0; k < len; k++) step(lv, $urandom_range(0, 199) == 0);
    end

    repeat (4) step(0, 0);
    @(negedge refclk);
    #1;
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Power-up and recovery sequencer for the core's PLL (50 MHz refclk in, 53.6 MHz core clock out).
- Drives the PLL reset and watches the asynchronous PLL locked output.
- Releases the system reset only after the lock has been continuously stable, and retries on lock timeout.
- Runs entirely in the refclk domain, so it keeps working when the PLL output clock is absent.

Parameters:
- RST_CYCLES, 16, refclk cycles pll_rst is held high per attempt (min 1)
- STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before release (min 1)
- LOCK_TIMEOUT, 65536, refclk cycles allowed in WAIT_LOCK before a retry (must be > STABLE_CYCLES)
- MAX_RETRY, 4, number of timeouts before entering FAULT (min 1)
- SYNC_STAGES, 2, flip-flop stages on pll_locked (min 2)

Ports:
- refclk  in  1  50 MHz reference clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- pll_locked  in  1  PLL locked output, asynchronous to refclk
- reconfig_req  in  1  single-cycle request to re-lock the PLL (e.g. after a mode change)
- pll_rst  out  1  reset to the PLL, active-high
- sys_rst  out  1  core reset, active-high; the consumer synchronizes deassertion into its own domain
- ready  out  1  high only in RUN
- fault  out  1  high only in FAULT
- retry_cnt  out  3  timeouts in the current sequence, saturating at 7
- lost_cnt  out  8  lock-loss events in RUN since rst, saturating at 255

Behaviour:
- Clocking and outputs: single clock refclk; rst is asynchronous, active-high. All outputs are registered.
- Reset values: state RESET_PLL, pll_rst=1, sys_rst=1, ready=0, fault=0, retry_cnt=0, lost_cnt=0, all counters 0, sync chain 0.
- Lock synchronizer: pll_locked passes through SYNC_STAGES flops to give lk. Latency is SYNC_STAGES cycles, and there is no glitch filtering beyond the stable counter.
- RESET_PLL:
  - pll_rst=1, sys_rst=1.
  - Counts RST_CYCLES cycles, then goes to WAIT_LOCK; pll_rst is low on the first WAIT_LOCK cycle.
- WAIT_LOCK:
  - pll_rst=0, sys_rst=1.
  - The timeout counter increments every cycle.
  - The stable counter increments while lk=1 and clears to 0 on any lk=0 cycle.
  - When the stable counter reaches STABLE_CYCLES: go to RUN.
  - Else, when the timeout counter reaches LOCK_TIMEOUT: retry_cnt++.
    - If the new retry_cnt equals MAX_RETRY: go to FAULT.
    - Otherwise: go to RESET_PLL.
  - If stable completion and timeout occur in the same cycle, stable completion wins.
- RUN:
  - sys_rst=0, ready=1, pll_rst=0, retry_cnt cleared to 0 on entry.
  - lk=0 for one cycle: lost_cnt++ and go to RESET_PLL. sys_rst=1 and ready=0 on the next cycle.
- FAULT:
  - fault=1, pll_rst=0, sys_rst=1, and there is no timeout.
  - The stable counter works as in WAIT_LOCK; on reaching STABLE_CYCLES go to RUN, with fault=0 and retry_cnt=0.
- reconfig_req:
  - Sampled in every state; it forces RESET_PLL on the next cycle and overrides all other same-cycle transitions.
  - When it arrives in RUN, it does not increment lost_cnt.
  - When it arrives in RESET_PLL, it restarts the RST_CYCLES count.
  - When it arrives in FAULT, it clears fault and retry_cnt.
- Counter reset: on every entry to RESET_PLL or WAIT_LOCK, the timeout and stable counters clear.
- Counter widths: sized with clog2 of their terminal values; saturating counters never wrap.
- rst asserted mid-sequence: immediate return to reset values, including pll_rst=1; the sequence restarts after deassertion.

Test Plan:
Benches use RST_CYCLES=4, STABLE_CYCLES=8, LOCK_TIMEOUT=64, MAX_RETRY=2, SYNC_STAGES=2.
1. Clean lock:
   - Stimulus: release rst; raise pll_locked 10 cycles after pll_rst falls.
   - Required: pll_rst high for exactly 4 cycles. sys_rst falls and ready rises 10+2+8 cycles after pll_rst falls, ±1 for boundary registration, checked exactly against the RTL counter convention.
2. Glitch during stabilization:
   - Stimulus: lock high for 5 cycles, low for 1 cycle, then high.
   - Required: stable count restarts; release comes 8 cycles after the re-rise plus sync latency; lost_cnt=0.
3. Timeout and fault:
   - Stimulus: pll_locked held at 0.
   - Required: two WAIT_LOCK windows of 64 cycles. retry_cnt goes 1, then FAULT with fault=1 and retry_cnt=2. pll_rst pulses exactly twice.
4. Recovery from fault:
   - Stimulus: while in FAULT, raise pll_locked.
   - Required: after 2+8 cycles, ready=1, fault=0, retry_cnt=0.
5. Lock loss and reconfig:
   - Stimulus: in RUN, drop pll_locked for 1 cycle.
   - Required: lost_cnt=1, sys_rst reasserts, a 4-cycle pll_rst pulse follows.
   - Stimulus: later, pulse reconfig_req in RUN.
   - Required: pll_rst pulse, lost_cnt stays 1.
6. Async reset mid-WAIT_LOCK and simultaneity:
   - Stimulus: assert rst during WAIT_LOCK.
   - Required: pll_rst=1 with no clock edge needed; all counters 0.
   - Stimulus: reconfig_req on the same cycle as stable completion.
   - Required: next state is RESET_PLL, ready stays 0.
